// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: packs stream words into 128-bit blocks, drives the aes_core handshake with optional CBC chaining, unpacks results
// Ports: clk/rst_i clock and async reset; dec_i/cbc_i mode (latched on LOAD entry); iv_i/iv_load_i chaining IV;
//   in_valid_i/in_ready_o/in_data_i input stream; out_valid_o/out_ready_i/out_data_o output stream; busy_o idle flag;
//   core_load_o/core_dec_o/core_data_o/core_data_i/core_busy_i aes_core interface.
module aes_stream_ctrl #(
  parameter int WORD_W = 32,
  parameter bit CBC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              dec_i,
  input  logic              cbc_i,
  input  logic [127:0]      iv_i,
  input  logic              iv_load_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              core_load_o,
  output logic              core_dec_o,
  output logic [127:0]      core_data_o,
  input  logic [127:0]      core_data_i,
  input  logic              core_busy_i
);
  localparam int NW = 128 / WORD_W;
  localparam logic [2:0] LAST = 3'(NW - 1);
  typedef enum logic [1:0] {FILL, LOAD, RUN, DRAIN} state_t;
  state_t       state_q;
  logic [2:0]   cnt_q;
  logic [127:0] blk_q, chain_q, res_q, core_data_q;
  logic         dec_q, cbc_q, load_q;
  logic         iv_wr, cbc_d;
  logic [127:0] blk_d, chain_d, res_d;
  assign in_ready_o  = state_q == FILL;
  assign out_valid_o = state_q == DRAIN;
  assign busy_o      = !(state_q == FILL && cnt_q == '0);
  assign out_data_o  = res_q[127 -: WORD_W];
  assign core_load_o = load_q;
  assign core_dec_o  = dec_q;
  assign core_data_o = core_data_q;
  assign iv_wr   = CBC_EN && state_q == FILL && cnt_q == '0 && iv_load_i;
  assign cbc_d   = CBC_EN && cbc_i;
  assign blk_d   = (blk_q << WORD_W) | 128'(in_data_i);
  // an IV written together with the first word must already chain that block
  assign chain_d = iv_wr ? iv_i : chain_q;
  assign res_d   = (dec_q && cbc_q) ? core_data_i ^ chain_q : core_data_i;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      blk_q       <= '0;
      chain_q     <= '0;
      res_q       <= '0;
      core_data_q <= '0;
      dec_q       <= 1'b0;
      cbc_q       <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (iv_wr) chain_q <= iv_i;
          if (in_valid_i) begin
            blk_q <= blk_d;
            cnt_q <= cnt_q == LAST ? '0 : cnt_q + 3'd1;
            if (cnt_q == LAST) begin
              state_q     <= LOAD;
              dec_q       <= dec_i;
              cbc_q       <= cbc_d;
              load_q      <= !core_busy_i;
              core_data_q <= (!dec_i && cbc_d) ? blk_d ^ chain_d : blk_d;
            end
          end
        end
        // a stale core operation (e.g. across our reset) must finish before we load
        LOAD: begin
          if (load_q && core_busy_i) begin
            load_q  <= 1'b0;
            state_q <= RUN;
          end else if (!core_busy_i) load_q <= 1'b1;
        end
        RUN: begin
          if (!core_busy_i) begin
            res_q   <= res_d;
            state_q <= DRAIN;
            if (cbc_q) chain_q <= dec_q ? blk_q : core_data_i;
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            res_q <= res_q << WORD_W;
            cnt_q <= cnt_q == LAST ? '0 : cnt_q + 3'd1;
            if (cnt_q == LAST) state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: table-driven and directed checks of aes_stream_ctrl against a behavioural aes_core stand-in
module tb_aes_stream_ctrl;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MASK = {32{4'ha}};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec = 1'b0, cbc = 1'b0, iv_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] iv = '0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, busy, core_load, core_dec;
  logic [31:0] out_data;
  logic [127:0] core_data;
  logic core_busy = 1'b0;
  logic [127:0] core_out = '0;
  int bcnt = 0;
  int lat = 6;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  aes_stream_ctrl #(.WORD_W(32), .CBC_EN(1'b1)) dut (
    .clk(clk), .rst_i(rst), .dec_i(dec), .cbc_i(cbc), .iv_i(iv), .iv_load_i(iv_load),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .core_load_o(core_load), .core_dec_o(core_dec),
    .core_data_o(core_data), .core_data_i(core_out), .core_busy_i(core_busy)
  );
  // stand-in core: knows the FIPS-197 AES-128 vector for key 000102..0f, anything else is masked
  function automatic logic [127:0] core_f(input logic [127:0] d, input logic dm);
    if (!dm) return d == PT ? CT : d ^ MASK;
    return d == CT ? PT : d ^ MASK;
  endfunction
  always @(posedge clk) begin
    if (core_load && !core_busy) begin
      core_busy <= 1'b1;
      bcnt      <= lat;
      core_out  <= core_f(core_data, core_dec);
    end else if (core_busy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) core_busy <= 1'b0;
    end
  end
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  // ivl_at: word index carrying iv_load_i, 4 = pulse in an idle cycle before the block, <0 = none
  task automatic send_block(input logic [127:0] blk, input logic d, input logic c, input int ivl_at, input logic [127:0] v);
    if (ivl_at == 4) begin
      @(negedge clk);
      iv = v;
      iv_load = 1'b1;
      @(negedge clk);
      iv_load = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) timeout("in_ready");
      in_valid = 1'b1;
      in_data  = blk[127-32*i -: 32];
      dec      = d;
      cbc      = c;
      iv       = v;
      iv_load  = (i == ivl_at);
    end
    @(negedge clk);
    in_valid = 1'b0;
    iv_load  = 1'b0;
    dec      = ~d;
    cbc      = ~c;
  endtask
  task automatic recv_block(output logic [127:0] got);
    got = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      while (!out_valid && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) begin
        timeout("out_valid");
        break;
      end
      got[127-32*i -: 32] = out_data;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask
  typedef struct {
    logic dec;
    logic cbc;
    int ivl_at;
    logic rst_before;
    logic [127:0] iv;
    logic [127:0] blk;
    logic [127:0] exp;
    string nm;
  } vec_t;
  vec_t vt[8];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] got;
    logic [127:0] ctv;
    logic bad;
    int t;
    ctv = CT;
    vt[0] = '{1'b0, 1'b0, -1, 1'b0, '0, PT, CT, "ecb_enc"};
    vt[1] = '{1'b1, 1'b0, -1, 1'b0, '0, CT, PT, "ecb_dec"};
    vt[2] = '{1'b1, 1'b1, 0, 1'b0, ONES, CT, 128'hffeeddccbbaa99887766554433221100, "cbc_dec_iv_with_word0"};
    vt[3] = '{1'b1, 1'b1, -1, 1'b0, '0, CT, 128'h69d5c2eb2e2e624750541d3bbc692ba5, "cbc_dec_chain_is_ct"};
    vt[4] = '{1'b0, 1'b1, 0, 1'b0, ONES, 128'hffeeddccbbaa99887766554433221100, CT, "cbc_enc_iv_with_word0"};
    vt[5] = '{1'b0, 1'b1, -1, 1'b0, '0, 128'h69d5c2eb2e2e624750541d3bbc692ba5, CT, "cbc_enc_chain_is_ct"};
    vt[6] = '{1'b0, 1'b1, 2, 1'b1, ONES, PT, CT, "cbc_enc_late_iv_ignored"};
    vt[7] = '{1'b1, 1'b1, 4, 1'b0, ONES, CT, 128'hffeeddccbbaa99887766554433221100, "cbc_dec_idle_iv"};
    #1;
    check("rst in_ready", 128'(in_ready), 128'd1);
    check("rst out_valid", 128'(out_valid), 128'd0);
    check("rst busy", 128'(busy), 128'd0);
    check("rst core_load", 128'(core_load), 128'd0);
    check("rst core_dec", 128'(core_dec), 128'd0);
    check("rst core_data", core_data, 128'd0);
    check("rst out_data", 128'(out_data), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // latency and back-pressure
    send_block(PT, 1'b0, 1'b0, -1, '0);
    check("lat core_load", 128'(core_load), 128'd1);
    check("lat busy", 128'(busy), 128'd1);
    check("lat in_ready", 128'(in_ready), 128'd0);
    check("lat core_data", core_data, PT);
    check("lat core_dec", 128'(core_dec), 128'd0);
    t = 0;
    while (!core_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    while (core_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("core_busy fall");
    check("busy fall same cycle out_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", 128'(out_valid), 128'd1);
      check("bp out_data", 128'(out_data), 128'(ctv[127:96]));
      check("bp in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    recv_block(got);
    check("bp drained block", got, CT);
    check("after drain out_valid", 128'(out_valid), 128'd0);
    check("after drain busy", 128'(busy), 128'd0);
    // vector table
    for (int k = 0; k < 8; k++) begin
      if (vt[k].rst_before) do_reset();
      lat = 3 + k;
      send_block(vt[k].blk, vt[k].dec, vt[k].cbc, vt[k].ivl_at, vt[k].iv);
      recv_block(got);
      for (int w = 0; w < 4; w++)
        check($sformatf("%s word%0d", vt[k].nm, w), 128'(got[127-32*w -: 32]), 128'(vt[k].exp[127-32*w -: 32]));
    end
    // reset while the core is running, then replay with the core still busy
    lat = 40;
    send_block(PT, 1'b0, 1'b0, -1, '0);
    t = 0;
    while (!core_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("core_busy rise");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst in_ready", 128'(in_ready), 128'd1);
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst core_load", 128'(core_load), 128'd0);
    check("midrst core_data", core_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 6;
    send_block(PT, 1'b0, 1'b0, -1, '0);
    check("stale core still busy", 128'(core_busy), 128'd1);
    bad = 1'b0;
    t = 0;
    while (core_busy && t < 100) begin
      if (core_load) bad = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("stale busy fall");
    check("core_load held during stale op", 128'(bad), 128'd0);
    @(negedge clk);
    check("core_load after stale op", 128'(core_load), 128'd1);
    recv_block(got);
    check("replay after reset", got, CT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
